// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: fetch controller state encoding and default PC parameters
package pc_ctrl_pkg;
    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        ERR
    } state_t;
    localparam logic [31:0] DEF_RESET_ADDR     = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_INC         = 32'd4;
    localparam int          DEF_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts unanswered fetch cycles and raises a sticky error at the limit
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_cyc,
    input  logic ack,
    output logic timeout,
    output logic err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    always_comb begin
        timeout = wait_cyc && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        cnt_d   = ack ? '0 : wait_cyc ? cnt_q + CW'(1) : cnt_q;
        err_d   = err_q | timeout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencing and instruction fetch handshake; FETCH_TIMEOUT_EN adds a fetch watchdog and ERR state
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
    parameter logic [31:0] PC_INC     = DEF_PC_INC
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        IMemAck,
    output logic        IMemReq,
    output logic [31:0] Address,
    output logic        PCWrite,
    output logic        InstrValid,
    output logic        Flush,
    output logic        FetchErr
);
    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic        redir;
    logic [31:0] target;
    logic [31:0] seq_addr;
    logic        timeout;
    assign redir    = BranchTaken | Jump;
    assign target   = BranchTaken ? BranchTarget : JumpTarget;
    assign seq_addr = PCResult + PC_INC;
`ifdef FETCH_TIMEOUT_EN
    logic wd_err;
    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (Clk),
        .rst     (Reset),
        .wait_cyc(state_q == FETCH && !IMemAck),
        .ack     (state_q == FETCH && IMemAck),
        .timeout (timeout),
        .err     (wd_err)
    );
    assign FetchErr = wd_err & ~Reset;
`else
    assign timeout  = 1'b0;
    assign FetchErr = 1'b0;
`endif
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        redir_addr_d = redir_addr_q;
        IMemReq      = 1'b0;
        PCWrite      = 1'b0;
        Address      = PCResult;
        InstrValid   = 1'b0;
        Flush        = 1'b0;
        if (Reset) begin
            Address = RESET_ADDR;
        end else begin
            case (state_q)
                BOOT: begin
                    PCWrite = 1'b1;
                    Address = RESET_ADDR;
                    state_d = FETCH;
                end
                FETCH: begin
                    IMemReq = 1'b1;
                    if (IMemAck) begin
                        if (redir || pending_q) begin
                            Flush     = 1'b1;
                            PCWrite   = 1'b1;
                            Address   = redir ? target : redir_addr_q;
                            pending_d = 1'b0;
                        end else begin
                            InstrValid = 1'b1;
                            PCWrite    = !Stall;
                            Address    = Stall ? PCResult : seq_addr;
                            state_d    = Stall ? HOLD : FETCH;
                        end
                    end else begin
                        // latest redirect wins; it is applied when the outstanding fetch returns
                        pending_d    = pending_q | redir;
                        redir_addr_d = redir ? target : redir_addr_q;
                        state_d      = timeout ? ERR : FETCH;
                    end
                end
                HOLD: begin
                    PCWrite = redir || !Stall;
                    Address = redir ? target : !Stall ? seq_addr : PCResult;
                    state_d = Stall ? HOLD : FETCH;
                end
                default: begin
                    Address = '0;
                end
            endcase
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= BOOT;
            pending_q    <= 1'b0;
            redir_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            redir_addr_q <= redir_addr_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed stimulus with a per-cycle reference model and literal spot checks
module tb_pc_fetch_ctrl;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PCResult;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        IMemAck = 1'b0;
    logic        IMemReq;
    logic [31:0] Address;
    logic        PCWrite;
    logic        InstrValid;
    logic        Flush;
    logic        FetchErr;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] pc = 32'h0;
    pc_fetch_ctrl dut (
        .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .IMemAck(IMemAck),
        .IMemReq(IMemReq), .Address(Address), .PCWrite(PCWrite),
        .InstrValid(InstrValid), .Flush(Flush), .FetchErr(FetchErr)
    );
    always #5 Clk = ~Clk;
    assign PCResult = pc;
    always @(posedge Clk) if (PCWrite) pc <= Address;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // Reference model: mode 0 = boot load, 1 = fetch outstanding, 2 = holding, 3 = error
    int          m_mode = 0, n_mode;
    bit          m_pend = 0, n_pend;
    logic [31:0] m_tgt = '0, n_tgt;
    int          m_wait = 0, n_wait;
    bit          m_err = 0, n_err;
    logic        e_req, e_we, e_iv, e_fl, e_err;
    logic [31:0] e_addr;
    task automatic model_eval;
        bit          rd;
        logic [31:0] t;
        rd = BranchTaken || Jump;
        t  = BranchTaken ? BranchTarget : JumpTarget;
        {e_req, e_we, e_iv, e_fl} = 4'b0;
        e_addr = pc;
        e_err  = m_err;
        {n_mode, n_pend, n_tgt, n_wait, n_err} = {m_mode, m_pend, m_tgt, m_wait, m_err};
        if (Reset) begin
            e_addr = 32'h0;
            e_err  = 1'b0;
            n_mode = 0; n_pend = 0; n_wait = 0; n_err = 0;
        end else if (m_mode == 0) begin
            e_we = 1; e_addr = 32'h0; n_mode = 1;
        end else if (m_mode == 1) begin
            e_req = 1;
            if (IMemAck && (rd || m_pend)) begin
                e_fl = 1; e_we = 1; e_addr = rd ? t : m_tgt; n_pend = 0; n_wait = 0;
            end else if (IMemAck) begin
                e_iv = 1; n_wait = 0;
                if (Stall) n_mode = 2;
                else begin e_we = 1; e_addr = pc + 32'd4; end
            end else begin
                if (rd) begin n_pend = 1; n_tgt = t; end
`ifdef FETCH_TIMEOUT_EN
                n_wait = m_wait + 1;
                if (n_wait == 16) begin n_mode = 3; n_err = 1; end
`endif
            end
        end else if (m_mode == 2) begin
            if (rd) begin e_we = 1; e_addr = t; end
            else if (!Stall) begin e_we = 1; e_addr = pc + 32'd4; end
            if (!Stall) n_mode = 1;
        end else begin
            e_addr = 32'h0;
        end
    endtask
    always @(negedge Clk) begin
        model_eval();
        chk("m_IMemReq", IMemReq, e_req);
        chk("m_PCWrite", PCWrite, e_we);
        chk("m_Address", Address, e_addr);
        chk("m_InstrValid", InstrValid, e_iv);
        chk("m_Flush", Flush, e_fl);
        chk("m_FetchErr", FetchErr, e_err);
        chk("m_iv_flush_excl", InstrValid & Flush, 1'b0);
    end
    always @(posedge Clk) begin
        {m_mode, m_pend, m_tgt, m_wait, m_err} = {n_mode, n_pend, n_tgt, n_wait, n_err};
    end
    task automatic cyc(input logic r, input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic ack);
        @(posedge Clk);
        #1;
        Reset = r; Stall = st; BranchTaken = br; BranchTarget = bt;
        Jump = jp; JumpTarget = jt; IMemAck = ack;
        @(negedge Clk);
    endtask
    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_req", IMemReq, 0);
        chk("rst_we", PCWrite, 0);
        chk("rst_addr", Address, 32'h0);
        chk("rst_err", FetchErr, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("boot_we", PCWrite, 1);
        chk("boot_addr", Address, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("seq0_addr", Address, 32'h4);
        chk("seq0_iv", InstrValid, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("seq1_addr", Address, 32'h8);
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("stall_iv", InstrValid, 1);
        chk("stall_we", PCWrite, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("hold_req", IMemReq, 0);
        chk("hold_we", PCWrite, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("unstall_addr", Address, 32'hC);
        chk("unstall_we", PCWrite, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("seq2_addr", Address, 32'h10);
        cyc(0, 0, 1, 32'h40, 0, 0, 0);
        chk("br_wait_we", PCWrite, 0);
        chk("br_wait_fl", Flush, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("br_ack_fl", Flush, 1);
        chk("br_ack_addr", Address, 32'h40);
        chk("br_ack_iv", InstrValid, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("br_next_pc", PCResult, 32'h40);
        chk("br_next_addr", Address, 32'h44);
        cyc(0, 0, 1, 32'h80, 1, 32'h100, 1);
        chk("brjp_addr", Address, 32'h80);
        chk("brjp_fl", Flush, 1);
        cyc(0, 0, 1, 32'h200, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h300, 0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("overwrite_addr", Address, 32'h300);
        chk("pend_stall_we", PCWrite, 1);
        cyc(0, 0, 1, 32'h500, 1, 32'h600, 0);
        chk("pend_stay_req", IMemReq, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("prio_pend_addr", Address, 32'h500);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h700, 0, 0, 0);
        chk("hold_br_addr", Address, 32'h700);
        chk("hold_br_fl", Flush, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("after_hold_br", Address, 32'h704);
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("wrap_addr", Address, 32'h0);
        chk("wrap_iv", InstrValid, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("midrst_req", IMemReq, 0);
        chk("midrst_iv", InstrValid, 0);
        chk("midrst_addr", Address, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reboot_addr", Address, 32'h0);
        chk("reboot_we", PCWrite, 1);
        for (int i = 0; i < 21; i++) cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
        chk("timeout_err", FetchErr, 1);
        chk("timeout_req", IMemReq, 0);
`else
        chk("noto_err", FetchErr, 0);
        chk("noto_req", IMemReq, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
